// File: rtl/route_sw_ctrl.sv
// rtl/route_sw_ctrl.sv - capacitor select mask controller for the route distributor
module route_sw_ctrl #(
    parameter int CHANNEL_NUM   = 35,
    parameter int CAPACITOR_NUM = 40,
    parameter int DWELL_W       = 16,
    parameter int CNT_W         = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic [DWELL_W-1:0]       dwell,
    input  logic                     cfg_valid,
    input  logic [CAPACITOR_NUM-1:0] cfg_mask,
    output logic                     cfg_ready,
    input  logic                     err_clr,
    output logic [CAPACITOR_NUM-1:0] sw,
    output logic                     sw_update,
    output logic                     err_popcnt
);

    typedef enum logic [1:0] {RUN, CHECK, APPLY} state_t;

    localparam logic [CAPACITOR_NUM-1:0] SW_RESET =
        {{(CAPACITOR_NUM-CHANNEL_NUM){1'b0}}, {CHANNEL_NUM{1'b1}}};
    localparam logic [CNT_W-1:0] CHAN_CNT = CNT_W'(CHANNEL_NUM);

    state_t                   state;
    logic [CAPACITOR_NUM-1:0] shadow;
    logic [CNT_W-1:0]         pop_q;
    logic [CNT_W-1:0]         pop_c;
    logic [DWELL_W-1:0]       cnt;
    logic [DWELL_W-1:0]       cnt_eff;
    logic                     rot_q;
    logic                     rot_en;
    logic                     handshake;
    logic                     tick;

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < CAPACITOR_NUM; i++) begin
            pop_c = pop_c + CNT_W'(shadow[i]);
        end
    end

    // rot_q remembers mode 1 from the previous RUN cycle, so entering mode 1 restarts the count at 0
    assign rot_en    = (mode == 2'd1);
    assign handshake = (state == RUN) && cfg_valid && cfg_ready;
    assign cnt_eff   = rot_q ? cnt : '0;
    assign tick      = (cnt_eff == dwell);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            shadow     <= '0;
            pop_q      <= '0;
            cnt        <= '0;
            rot_q      <= 1'b0;
            sw         <= SW_RESET;
            sw_update  <= 1'b0;
            err_popcnt <= 1'b0;
            cfg_ready  <= 1'b1;
        end else begin
            sw_update <= 1'b0;
            if (err_clr) begin
                err_popcnt <= 1'b0;
            end
            case (state)
                RUN: begin
                    rot_q <= rot_en;
                    if (handshake) begin
                        shadow    <= cfg_mask;
                        state     <= CHECK;
                        cfg_ready <= 1'b0;
                        if (rot_en) begin
                            cnt <= cnt_eff;
                        end
                    end else if (rot_en) begin
                        if (tick) begin
                            cnt       <= '0;
                            sw        <= {sw[CAPACITOR_NUM-2:0], sw[CAPACITOR_NUM-1]};
                            sw_update <= 1'b1;
                        end else begin
                            cnt <= cnt_eff + DWELL_W'(1);
                        end
                    end
                end
                CHECK: begin
                    pop_q <= pop_c;
                    state <= APPLY;
                end
                APPLY: begin
                    // a failing popcount sets the flag even when err_clr is high this cycle
                    if (pop_q == CHAN_CNT) begin
                        sw        <= shadow;
                        sw_update <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        err_popcnt <= 1'b1;
                    end
                    state     <= RUN;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    state     <= RUN;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
